// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC output arbiter.
package noc_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int RESP_REQ  = 0;
  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/noc_out_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after i_ptr, modulo NREQ.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_gnt_idx,
  output logic            o_any
);

  // One spare bit so ptr+k cannot overflow before the explicit wrap.
  logic [IDW:0] w_idx;
  logic         w_found;

  always_comb begin
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && i_req[w_idx[IDW-1:0]]) begin
        w_found   = 1'b1;
        o_gnt_idx = w_idx[IDW-1:0];
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/noc_out_arbiter.sv
// Packet-granular round-robin arbiter for the tile's NoC output stream; grant held until TLAST.
// Optional macro NOC_ARB_RESP_PRIO_EN gives requester 0 (decoder responses) strict priority in IDLE.
module noc_out_arbiter
  import noc_arb_pkg::*;
#(
  parameter int BW   = 32,
  parameter int BWB  = BW / 8,
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk_ctrl,
  input  logic                  clk_ctrl_rst,
  input  logic [NREQ-1:0]       req_TVALID,
  input  logic [NREQ*BW-1:0]    req_TDATA,
  input  logic [NREQ*BWB-1:0]   req_TKEEP,
  input  logic [NREQ-1:0]       req_TLAST,
  output logic [NREQ-1:0]       req_TREADY,
  output logic                  stream_out_TVALID,
  output logic [BW-1:0]         stream_out_TDATA,
  output logic [BWB-1:0]        stream_out_TKEEP,
  output logic                  stream_out_TLAST,
  input  logic                  stream_out_TREADY,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic [PKT_CNT_W-1:0]  pkt_count
);

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  logic [IDW-1:0]       r_grant_id;
  logic [IDW-1:0]       w_grant_nxt;
  logic [IDW-1:0]       r_rr_ptr;
  logic [IDW-1:0]       w_rr_ptr_nxt;
  logic [PKT_CNT_W-1:0] r_pkt_count;

  logic [NREQ-1:0]      w_rr_req;
  logic [IDW-1:0]       w_rr_idx;
  logic                 w_rr_any;
  logic [IDW-1:0]       w_pick_idx;
  logic                 w_pick_any;
  logic                 w_eop;
  logic                 w_ptr_upd;

  logic                 w_sel_vld;
  logic [BW-1:0]        w_sel_dat;
  logic [BWB-1:0]       w_sel_keep;
  logic                 w_sel_last;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .i_req     (w_rr_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt_idx (w_rr_idx),
    .o_any     (w_rr_any)
  );

`ifdef NOC_ARB_RESP_PRIO_EN
  // Response path bypasses the rotation; the others rotate among themselves.
  always_comb begin
    w_rr_req           = req_TVALID;
    w_rr_req[RESP_REQ] = 1'b0;
  end
  assign w_pick_any = w_rr_any | req_TVALID[RESP_REQ];
  assign w_pick_idx = req_TVALID[RESP_REQ] ? IDW'(RESP_REQ) : w_rr_idx;
  assign w_ptr_upd  = w_eop && (r_grant_id != IDW'(RESP_REQ));
`else
  assign w_rr_req   = req_TVALID;
  assign w_pick_any = w_rr_any;
  assign w_pick_idx = w_rr_idx;
  assign w_ptr_upd  = w_eop;
`endif

  assign w_sel_vld  = req_TVALID[r_grant_id];
  assign w_sel_dat  = req_TDATA[int'(r_grant_id)*BW +: BW];
  assign w_sel_keep = req_TKEEP[int'(r_grant_id)*BWB +: BWB];
  assign w_sel_last = req_TLAST[r_grant_id];

  assign w_rr_ptr_nxt = (r_grant_id == IDW'(NREQ-1)) ? '0 : r_grant_id + IDW'(1);

  always_comb begin
    w_next_state      = r_state;
    w_grant_nxt       = r_grant_id;
    w_eop             = 1'b0;
    stream_out_TVALID = 1'b0;
    stream_out_TDATA  = '0;
    stream_out_TKEEP  = '0;
    stream_out_TLAST  = 1'b0;
    req_TREADY        = '0;
    busy              = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_next_state = ARB_GRANT;
          w_grant_nxt  = w_pick_idx;
        end
      end
      ARB_GRANT: begin
        stream_out_TVALID      = w_sel_vld;
        stream_out_TDATA       = w_sel_dat;
        stream_out_TKEEP       = w_sel_keep;
        stream_out_TLAST       = w_sel_last;
        req_TREADY[r_grant_id] = stream_out_TREADY;
        busy                   = 1'b1;
        if (w_sel_vld && stream_out_TREADY && w_sel_last) begin
          w_next_state = ARB_IDLE;
          w_eop        = 1'b1;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
    if (clk_ctrl_rst) begin
      r_state     <= ARB_IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_grant_id <= w_grant_nxt;
      if (w_ptr_upd) begin
        r_rr_ptr <= w_rr_ptr_nxt;
      end
      if (w_eop) begin
        r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
      end
    end
  end

  assign grant_id  = r_grant_id;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Self-checking bench for noc_out_arbiter: packet-level model plus literal pins.
module tb_noc_out_arbiter;

  localparam int BW   = 32;
  localparam int BWB  = 4;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                 clk_ctrl = 1'b0;
  logic                 clk_ctrl_rst;
  logic [NREQ-1:0]      req_TVALID;
  logic [NREQ*BW-1:0]   req_TDATA;
  logic [NREQ*BWB-1:0]  req_TKEEP;
  logic [NREQ-1:0]      req_TLAST;
  logic [NREQ-1:0]      req_TREADY;
  logic                 stream_out_TVALID;
  logic [BW-1:0]        stream_out_TDATA;
  logic [BWB-1:0]       stream_out_TKEEP;
  logic                 stream_out_TLAST;
  logic                 stream_out_TREADY;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic [15:0]          pkt_count;

  noc_out_arbiter #(.BW(BW), .BWB(BWB), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk_ctrl          (clk_ctrl),
    .clk_ctrl_rst      (clk_ctrl_rst),
    .req_TVALID        (req_TVALID),
    .req_TDATA         (req_TDATA),
    .req_TKEEP         (req_TKEEP),
    .req_TLAST         (req_TLAST),
    .req_TREADY        (req_TREADY),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .stream_out_TREADY (stream_out_TREADY),
    .grant_id          (grant_id),
    .busy              (busy),
    .pkt_count         (pkt_count)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  typedef struct packed {
    logic [BW-1:0]  d;
    logic [BWB-1:0] k;
    logic           l;
  } beat_t;

  beat_t           srcq [NREQ][$];
  logic [NREQ-1:0] src_en;
  int              checks   = 0;
  int              failures = 0;
  int              gnt_log[$];
  logic            prev_busy = 1'b0;

  // Model: owner = -1 when no packet is in flight.
  int m_owner, m_gid, m_ptr, m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
`ifdef NOC_ARB_RESP_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
`ifdef NOC_ARB_RESP_PRIO_EN
      if (j == 0) continue;
`endif
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_en[i] && srcq[i].size() > 0) begin
        req_TVALID[i]            = 1'b1;
        req_TDATA[i*BW +: BW]    = srcq[i][0].d;
        req_TKEEP[i*BWB +: BWB]  = srcq[i][0].k;
        req_TLAST[i]             = srcq[i][0].l;
      end else begin
        req_TVALID[i]            = 1'b0;
        req_TDATA[i*BW +: BW]    = '0;
        req_TKEEP[i*BWB +: BWB]  = '0;
        req_TLAST[i]             = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int r, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      beat_t bt;
      bt.d = base + 32'(b);
      bt.k = 4'hF - 4'(b);
      bt.l = (b == n - 1);
      srcq[r].push_back(bt);
    end
    drive_inputs();
  endtask

  // One clock: compare at negedge, then advance model and sources after the edge.
  task automatic cycle();
    logic [BW-1:0]   e_d;
    logic [BWB-1:0]  e_k;
    logic            e_v, e_l, e_busy, fire, last;
    logic [NREQ-1:0] e_rdy;
    int              own;
    @(negedge clk_ctrl);
    if (clk_ctrl_rst) begin
      m_owner = -1; m_gid = 0; m_ptr = 0; m_cnt = 0;
    end
    e_v = 0; e_d = '0; e_k = '0; e_l = 0; e_rdy = '0; e_busy = 0;
    if (m_owner >= 0) begin
      e_v    = req_TVALID[m_owner];
      e_d    = req_TDATA[m_owner*BW +: BW];
      e_k    = req_TKEEP[m_owner*BWB +: BWB];
      e_l    = req_TLAST[m_owner];
      e_rdy[m_owner] = stream_out_TREADY;
      e_busy = 1'b1;
    end
    chk("tvalid", stream_out_TVALID, e_v);
    chk("tdata", stream_out_TDATA, e_d);
    chk("tkeep", stream_out_TKEEP, e_k);
    chk("tlast", stream_out_TLAST, e_l);
    chk("req_tready", req_TREADY, e_rdy);
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, m_gid);
    chk("pkt_count", pkt_count, m_cnt);
    if (busy && !prev_busy) gnt_log.push_back(int'(grant_id));
    prev_busy = busy;
    own  = m_owner;
    fire = !clk_ctrl_rst && own >= 0 && req_TVALID[own] && stream_out_TREADY;
    last = (own >= 0) ? req_TLAST[own] : 1'b0;
    @(posedge clk_ctrl);
    #1;
    if (!clk_ctrl_rst) begin
      if (own < 0) begin
        int p;
        p = pick(req_TVALID, m_ptr);
        if (p >= 0) begin
          m_owner = p;
          m_gid   = p;
        end
      end else if (fire) begin
        void'(srcq[own].pop_front());
        if (last) begin
          m_owner = -1;
          m_cnt   = (m_cnt + 1) % 65536;
`ifdef NOC_ARB_RESP_PRIO_EN
          if (own != 0) m_ptr = (own + 1) % NREQ;
`else
          m_ptr = (own + 1) % NREQ;
`endif
        end
      end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    drive_inputs();
    clk_ctrl_rst = 1'b1;
    cycle();
    clk_ctrl_rst = 1'b0;
    gnt_log.delete();
  endtask

  int exp_t2[4];
  int exp_t7[3];
  logic [0:3] bp_pat;

  initial begin
    clk_ctrl_rst      = 1'b1;
    stream_out_TREADY = 1'b1;
    src_en            = '1;
    req_TVALID = '0; req_TDATA = '0; req_TKEEP = '0; req_TLAST = '0;
    m_owner = -1; m_gid = 0; m_ptr = 0; m_cnt = 0;
    #2;
    repeat (2) cycle();
    chk("reset_busy_lit", busy, 1'b0);
    chk("reset_cnt_lit", pkt_count, 16'd0);
    clk_ctrl_rst = 1'b0;

    // Single requester, 3 beats
    push_pkt(1, 3, 32'hA000_0000);
    repeat (6) cycle();
    chk("t1_cnt_lit", pkt_count, 16'd1);
    chk("t1_gid_lit", grant_id, 2'd1);

    // Full contention, 2-beat packets, ptr back at 0
    do_reset();
    push_pkt(0, 2, 32'hB000_0000);
    push_pkt(0, 2, 32'hB000_0010);
    push_pkt(1, 2, 32'hB100_0000);
    push_pkt(2, 2, 32'hB200_0000);
    repeat (16) cycle();
`ifdef NOC_ARB_RESP_PRIO_EN
    exp_t2 = '{0, 0, 1, 2};
`else
    exp_t2 = '{0, 1, 2, 0};
`endif
    chk("t2_npkts", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) chk("t2_order", gnt_log[i], exp_t2[i]);
    chk("t2_cnt_lit", pkt_count, 16'd4);

    // Back-pressure on a 4-beat packet from req2
    push_pkt(2, 4, 32'hC000_0000);
    cycle();
    bp_pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      stream_out_TREADY = bp_pat[i];
      cycle();
    end
    stream_out_TREADY = 1'b1;
    repeat (4) cycle();
    chk("t3_cnt_lit", pkt_count, 16'd5);

    // Reset after beat 2 of 4, source still presenting during the reset cycle
    push_pkt(1, 4, 32'hD000_0000);
    repeat (3) cycle();
    clk_ctrl_rst = 1'b1;
    cycle();
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    drive_inputs();
    clk_ctrl_rst = 1'b0;
    cycle();
    chk("t4_gid_lit", grant_id, 2'd0);
    chk("t4_cnt_lit", pkt_count, 16'd0);

    // Counter wrap
    force dut.r_pkt_count = 16'hFFFF;
    m_cnt = 65535;
    cycle();
    release dut.r_pkt_count;
    cycle();
    push_pkt(0, 1, 32'hE000_0000);
    repeat (3) cycle();
    chk("t5_wrap_lit", pkt_count, 16'd0);

    // Granted requester drops valid mid-packet; another requester must wait
    push_pkt(2, 3, 32'hF000_0000);
    repeat (2) cycle();
    src_en[2] = 1'b0;
    push_pkt(1, 1, 32'hF800_0000);
    repeat (2) cycle();
    chk("t6_hold_gid_lit", grant_id, 2'd2);
    chk("t6_hold_vld_lit", stream_out_TVALID, 1'b0);
    src_en[2] = 1'b1;
    drive_inputs();
    repeat (6) cycle();

    // Response priority scenario
    do_reset();
    push_pkt(1, 3, 32'h1100_0000);
    push_pkt(2, 2, 32'h2200_0000);
    repeat (2) cycle();
    push_pkt(0, 2, 32'h0000_00A0);
    repeat (14) cycle();
`ifdef NOC_ARB_RESP_PRIO_EN
    exp_t7 = '{1, 0, 2};
`else
    exp_t7 = '{1, 2, 0};
`endif
    chk("t7_npkts", gnt_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < gnt_log.size()) chk("t7_order", gnt_log[i], exp_t7[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the tile's single NoC output AXI-stream among NREQ local requesters.
- Requesters: 0 = NoC decoder response path (MPUT/MACK/MDATA replies); 1 = processor-side request path; 2 = DMA/message-queue sender.
- Grant is held from the first beat to TLAST, so packets never interleave on the mesh link.
- Sits between the tile-local stream sources and the router injection port.

Parameters:
- BW, 32, data width in bits.
- BWB, BW/8, TKEEP width.
- NREQ, 3, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the grant index.

Ports:
- clk_ctrl  in  1  control clock.
- clk_ctrl_rst  in  1  asynchronous, active-high reset.
- req_TVALID  in  NREQ  per-requester valid.
- req_TDATA  in  NREQ*BW  requester i occupies bits [i*BW +: BW].
- req_TKEEP  in  NREQ*BWB  requester i occupies bits [i*BWB +: BWB].
- req_TLAST  in  NREQ  per-requester last beat.
- req_TREADY  out  NREQ  per-requester ready.
- stream_out_TVALID  out  1  to router.
- stream_out_TDATA  out  BW.
- stream_out_TKEEP  out  BWB.
- stream_out_TLAST  out  1.
- stream_out_TREADY  in  1  from router.
- grant_id  out  IDW  index of the current owner.
- busy  out  1  a packet is in flight.
- pkt_count  out  16  completed packets, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (async, on clk_ctrl_rst high): state=IDLE, grant_id=0, rr_ptr=0, pkt_count=0.
  - All outputs 0: req_TREADY=0, stream_out_TVALID=0, TDATA=0, TKEEP=0, TLAST=0, busy=0.
- States: IDLE, GRANT.
- IDLE:
  - Output stream is driven to zero and all req_TREADY=0.
  - If any req_TVALID=1, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register the pick into grant_id and go to GRANT on the next edge.
  - Arbitration latency: one cycle from valid to first beat presented.
- GRANT:
  - Combinational pass-through of the granted requester: stream_out_TVALID/TDATA/TKEEP/TLAST = req_*[grant_id].
  - req_TREADY[grant_id] = stream_out_TREADY; all other req_TREADY = 0.
  - busy = 1.
- Beat transfer: stream_out_TVALID & stream_out_TREADY.
- End of packet: transfer with TLAST=1. Then:
  - next state IDLE;
  - rr_ptr = (grant_id+1) mod NREQ, with explicit wrap for non-power-of-2 NREQ;
  - pkt_count += 1.
- Granted requester drops TVALID mid-packet: grant is held; output valid follows the input; no re-arbitration until TLAST.
- Single-beat packet (TLAST on the first beat): one GRANT cycle when TREADY=1, then IDLE.
- Back-to-back packets: minimum one IDLE bubble cycle between packets, even from the same requester.
- stream_out_TREADY low: the beat stalls, TVALID/TDATA stay stable, and grant is held.
- A requester asserting TVALID while another holds the grant waits. Its data is not sampled.
- Reset mid-packet: the state is abandoned immediately. The router sees TVALID fall. Recovery is upstream's responsibility.
- Requesters must hold TVALID/TDATA stable until accepted (AXI-S rule). The arbiter adds no buffering.

Optional Feature:
- Macro: NOC_ARB_RESP_PRIO_EN.
- Defined:
  - In IDLE, requester 0 (decoder response path) wins whenever req_TVALID[0]=1, regardless of rr_ptr.
  - The remaining requesters rotate round-robin among themselves.
  - rr_ptr is updated only when a requester other than 0 completes a packet.
  - Purpose: guarantees MLOAD/MSTORE replies are never starved, avoiding remote-tile blocking deadlock.
- Undefined: pure round-robin over all NREQ as above.

Decomposition:
- Package noc_arb_pkg:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;
  - localparam RESP_REQ = 0;
  - localparam PKT_CNT_W = 16.
- Sub-module rr_pick:
  - Purely combinational rotating priority encoder.
  - Inputs: req vector [NREQ], ptr [IDW]. Outputs: gnt_idx [IDW], any.
  - The top level holds the state machine, registers and muxing.

Test Plan:
- Single requester, no contention: req1 sends 3 beats A0,A1,A2 (TLAST on A2), TREADY=1. Expect out beats on cycles 2-4, grant_id=1, then IDLE, pkt_count=1, rr_ptr=2.
- Full contention: all three valid with 2-beat packets, rr_ptr=0. Expect grant order 0,1,2,0, with exactly one IDLE cycle between packets and no interleaved beats.
- Back-pressure: stream_out_TREADY toggles 1,0,0,1 during a 4-beat packet from req2. Expect TDATA stable while stalled, req_TREADY[2] mirroring TREADY, and req_TREADY[0,1]=0 throughout.
- Reset mid-packet: assert clk_ctrl_rst after beat 2 of 4. Expect all outputs 0 in the same cycle, and grant_id=0, pkt_count=0 after release.
- Wrap: preload 65535 completed packets (or force pkt_count=16'hFFFF), then complete one packet. Expect pkt_count=0.
- With NOC_ARB_RESP_PRIO_EN: req1 and req2 continuously valid, req0 asserts during req1's packet. Expect req0 granted next, then req2. Without the macro, the order is req2 then req0.
